// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable multi-channel clock divider:
// default widths and reset divisor, the per-channel operating mode enum, the
// divisor-select width helper and the half-period threshold helper.
// Optional feature macro used by the divider files: CLKDIV_ALIGN_EN.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int NCH_MAX     = 8;
  localparam int CW_DEF      = 8;
  localparam int DIV_RST_DEF = 1;

  // Widest divisor the threshold helper handles; channels zero-extend into it.
  localparam int CW_MAX = 16;
  localparam int THR_W  = CW_MAX + 1;

  // What a channel does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_IDLE  = 2'd1,
    MODE_ALIGN = 2'd2,
    MODE_RUN   = 2'd3
  } chan_mode_e;

  // Width of the channel-select bus; a single channel still gets one bit.
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Number of leading high cycles in a period: ceil(R/2) = (div+2)>>1.
  // Computed one bit wider so div = all-ones does not wrap.
  function automatic logic [THR_W-1:0] half_thr(input logic [CW_MAX-1:0] div);
    logic [CW_MAX+1:0] sum;
    sum = {2'b00, div} + {{CW_MAX{1'b0}}, 2'b10};
    return sum[CW_MAX+1:1];
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel. Counts enabled cycles up to its divisor, pulses tick_o
// on the terminal cycle and drives a near-50% level on clk_o. A new divisor is
// parked in a shadow register and only takes over at a terminal count (or
// while the channel is idle), so a running period is never cut short.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   ena         global enable; low freezes every register here
//   ch_en       channel run enable
//   align       (CLKDIV_ALIGN_EN only) force running channel to phase 0
//   wr, wr_val  decoded divisor write strobe and value
//   div_pend    shadow divisor waiting to be applied
//   tick_o      one-cycle strobe per period
//   clk_o       divided level, high ceil(R/2) / low floor(R/2) cycles
// Macro: CLKDIV_ALIGN_EN adds the align input.
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          ch_en,
`ifdef CLKDIV_ALIGN_EN
  input  logic          align,
`endif
  input  logic          wr,
  input  logic [CW-1:0] wr_val,
  output logic          div_pend,
  output logic          tick_o,
  output logic          clk_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          clk_q, clk_d;

  chan_mode_e    mode;
  logic          align_req;
  logic          terminal;

  assign terminal = (cnt_q == div_q);

  // Pick this edge's behaviour: a frozen global enable beats everything, an
  // idle channel ignores align, and align beats normal counting.
  always_comb begin
    align_req = 1'b0;
`ifdef CLKDIV_ALIGN_EN
    align_req = align;
`endif
    if (!ena) begin
      mode = MODE_HOLD;
    end else if (!ch_en) begin
      mode = MODE_IDLE;
    end else if (align_req) begin
      mode = MODE_ALIGN;
    end else begin
      mode = MODE_RUN;
    end
  end

  // Next-state logic. A pending divisor is applied on idle, align or terminal
  // edges using the shadow value from before the edge; a write on the same
  // edge then re-arms the pending flag, so it waits for the next terminal.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = tick_q;
    clk_d    = clk_q;

    case (mode)
      MODE_IDLE: begin
        cnt_d  = '0;
        tick_d = 1'b0;
        clk_d  = 1'b0;
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end
      MODE_ALIGN: begin
        cnt_d  = '0;
        tick_d = 1'b0;
        clk_d  = 1'b1;
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end
      MODE_RUN: begin
        if (terminal) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          tick_d = 1'b0;
        end
        // Count 0 always lands below the threshold, so the level rises on
        // the terminal edge together with the tick.
        clk_d = (THR_W'(cnt_d) < half_thr(CW_MAX'(div_q)));
      end
      default: begin
      end
    endcase

    if (ena && wr) begin
      shadow_d = wr_val;
      pend_d   = 1'b1;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= CW'(DIV_RST);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      clk_q    <= clk_d;
    end
  end

  assign div_pend = pend_q;
  assign tick_o   = tick_q;
  assign clk_o    = clk_q;

endmodule

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Programmable multi-channel synchronous clock divider. Every channel runs off
// the single system clock and produces clock-enable style outputs only.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   ena            global enable (freezes all channels when low)
//   ch_en[NCH]     per-channel run enable
//   div_wr         one-cycle divisor write strobe
//   div_sel        channel addressed by div_wr (out-of-range ignored)
//   div_val        new divisor, ratio R = div_val + 1
//   align          (CLKDIV_ALIGN_EN only) phase-align all running channels
//   div_pend[NCH]  written divisor waiting for its terminal count
//   tick_o[NCH]    one-cycle strobe per period
//   clk_o[NCH]     divided level
// Macro: CLKDIV_ALIGN_EN adds the align input.
// -----------------------------------------------------------------------------
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CW      = CW_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NCH-1:0]            ch_en,
  input  logic                      div_wr,
  input  logic [sel_width(NCH)-1:0] div_sel,
  input  logic [CW-1:0]             div_val,
`ifdef CLKDIV_ALIGN_EN
  input  logic                      align,
`endif
  output logic [NCH-1:0]            div_pend,
  output logic [NCH-1:0]            tick_o,
  output logic [NCH-1:0]            clk_o
);

  localparam int SW = sel_width(NCH);

  logic [NCH-1:0] wr_stb;

  // One channel per index; a select value with no matching channel raises no
  // strobe at all, which is how out-of-range writes get dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr_stb[i] = div_wr && (div_sel == SW'(i));

    clk_div_chan #(
      .CW      (CW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .ch_en    (ch_en[i]),
`ifdef CLKDIV_ALIGN_EN
      .align    (align),
`endif
      .wr       (wr_stb[i]),
      .wr_val   (div_val),
      .div_pend (div_pend[i]),
      .tick_o   (tick_o[i]),
      .clk_o    (clk_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog (NCH=4, CW=8). A period-position model
// (position modulo ratio R) predicts every output each cycle; directed
// sequences with literal patterns pin the model, then random traffic runs.
// Macro: CLKDIV_ALIGN_EN enables the align stimulus and checks.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int NCH       = 4;
  localparam int CW        = 8;
  localparam int DEFAULT_R = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ena;
  logic [NCH-1:0] ch_en;
  logic           div_wr;
  logic [1:0]     div_sel;
  logic [CW-1:0]  div_val;
`ifdef CLKDIV_ALIGN_EN
  logic           align;
`endif
  logic [NCH-1:0] div_pend;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] clk_o;

  int tests_run    = 0;
  int tests_failed = 0;
  bit cmp_on       = 1'b0;

  // Model state: position inside the current period, ratio, pending ratio.
  int m_pos  [NCH];
  int m_r    [NCH];
  int m_pr   [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  bit m_clk  [NCH];

  // Hand-derived output patterns, one entry per edge.
  int pat_t2 [4] = '{0, 1, 0, 1};
  int pat_c2 [4] = '{0, 1, 0, 1};
  int pat_t5 [5] = '{0, 0, 0, 0, 1};
  int pat_c5 [5] = '{1, 1, 0, 0, 1};
  int pat_t3 [6] = '{0, 0, 1, 0, 0, 1};
  int pat_c3 [6] = '{1, 0, 1, 1, 0, 1};

  clk_div_prog #(
    .NCH     (NCH),
    .CW      (CW),
    .DIV_RST (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .ch_en    (ch_en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
`ifdef CLKDIV_ALIGN_EN
    .align    (align),
`endif
    .div_pend (div_pend),
    .tick_o   (tick_o),
    .clk_o    (clk_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input logic [NCH-1:0] en,
                               input bit wr, input int sel, input int val);
    ena     = e;
    ch_en   = en;
    div_wr  = wr;
    div_sel = 2'(sel);
    div_val = CW'(val);
  endtask

  task automatic wait_edge();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = 0;
      m_r[i]    = DEFAULT_R;
      m_pr[i]   = 0;
      m_pend[i] = 1'b0;
      m_tick[i] = 1'b0;
      m_clk[i]  = 1'b0;
    end
  endtask

  // One clock edge of the specification's behaviour, from pre-edge inputs.
  task automatic model_step();
    bit al;
    al = 1'b0;
`ifdef CLKDIV_ALIGN_EN
    al = align;
`endif
    if (!ena) return;
    for (int i = 0; i < NCH; i++) begin
      if (ch_en[i] && al) begin
        if (m_pend[i]) begin
          m_r[i]    = m_pr[i];
          m_pend[i] = 1'b0;
        end
        m_pos[i]  = 0;
        m_tick[i] = 1'b0;
        m_clk[i]  = 1'b1;
      end else if (!ch_en[i]) begin
        if (m_pend[i]) begin
          m_r[i]    = m_pr[i];
          m_pend[i] = 1'b0;
        end
        m_pos[i]  = 0;
        m_tick[i] = 1'b0;
        m_clk[i]  = 1'b0;
      end else begin
        m_pos[i]  = (m_pos[i] + 1) % m_r[i];
        m_tick[i] = (m_pos[i] == 0);
        m_clk[i]  = (m_pos[i] < (m_r[i] + 1) / 2);
        if (m_pos[i] == 0 && m_pend[i]) begin
          m_r[i]    = m_pr[i];
          m_pend[i] = 1'b0;
        end
      end
      if (div_wr && int'(div_sel) == i) begin
        m_pr[i]   = int'(div_val) + 1;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [NCH-1:0] model_vec(input int which);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      case (which)
        0:       v[i] = m_tick[i];
        1:       v[i] = m_clk[i];
        default: v[i] = m_pend[i];
      endcase
    end
    return v;
  endfunction

  // Reference model advances on every edge and clears on reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare all outputs against the model every cycle, mid-period.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        checkOutput("model_tick", 32'(tick_o), 32'(model_vec(0)));
        checkOutput("model_clk", 32'(clk_o), 32'(model_vec(1)));
        checkOutput("model_pend", 32'(div_pend), 32'(model_vec(2)));
      end
    end
  end

  // Directed sequences with literal expectations, then random traffic.
  initial begin
    bit seen;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0000, 1'b0, 0, 0);
`ifdef CLKDIV_ALIGN_EN
    align = 1'b0;
`endif
    #1 rst_n = 1'b0;
    wait_edge();
    wait_edge();
    checkOutput("reset_tick", 32'(tick_o), 32'd0);
    checkOutput("reset_clk", 32'(clk_o), 32'd0);
    checkOutput("reset_pend", 32'(div_pend), 32'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    wait_edge();

    // ch0 at the reset ratio of 2
    applyStimulus(1'b1, 4'b0001, 1'b0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wait_edge();
      checkOutput("ch0_r2_tick", 32'(tick_o[0]), 32'(pat_t2[k]));
      checkOutput("ch0_r2_clk", 32'(clk_o[0]), 32'(pat_c2[k]));
    end

    // ch1: write R=5 on its terminal edge; applied one period later
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    applyStimulus(1'b1, 4'b0011, 1'b1, 1, 4);
    wait_edge();
    checkOutput("ch1_wr_pend", 32'(div_pend[1]), 32'd1);
    checkOutput("ch1_wr_tick", 32'(tick_o[1]), 32'd1);
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    checkOutput("ch1_old_pend", 32'(div_pend[1]), 32'd1);
    checkOutput("ch1_old_tick", 32'(tick_o[1]), 32'd0);
    wait_edge();
    checkOutput("ch1_apply_pend", 32'(div_pend[1]), 32'd0);
    checkOutput("ch1_apply_tick", 32'(tick_o[1]), 32'd1);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        wait_edge();
        checkOutput("ch1_r5_tick", 32'(tick_o[1]), 32'(pat_t5[k]));
        checkOutput("ch1_r5_clk", 32'(clk_o[1]), 32'(pat_c5[k]));
      end
    end

    // ch2: R=1 loaded while idle, then enable and disable
    applyStimulus(1'b1, 4'b0011, 1'b1, 2, 0);
    wait_edge();
    checkOutput("ch2_pend_set", 32'(div_pend[2]), 32'd1);
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    checkOutput("ch2_pend_idle_apply", 32'(div_pend[2]), 32'd0);
    applyStimulus(1'b1, 4'b0111, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      wait_edge();
      checkOutput("ch2_r1_tick", 32'(tick_o[2]), 32'd1);
      checkOutput("ch2_r1_clk", 32'(clk_o[2]), 32'd1);
    end
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    checkOutput("ch2_off_tick", 32'(tick_o[2]), 32'd0);
    checkOutput("ch2_off_clk", 32'(clk_o[2]), 32'd0);

    // ch3: R=5, then writes of 7 and 2 inside one period; only R=3 lands
    applyStimulus(1'b1, 4'b0011, 1'b1, 3, 4);
    wait_edge();
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    applyStimulus(1'b1, 4'b1011, 1'b0, 0, 0);
    wait_edge();
    applyStimulus(1'b1, 4'b1011, 1'b1, 3, 7);
    wait_edge();
    applyStimulus(1'b1, 4'b1011, 1'b1, 3, 2);
    wait_edge();
    applyStimulus(1'b1, 4'b1011, 1'b0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      wait_edge();
      if (!div_pend[3]) seen = 1'b1;
    end
    checkOutput("ch3_pend_fall_in_time", 32'(seen), 32'd1);
    for (int k = 0; k < 6; k++) begin
      wait_edge();
      checkOutput("ch3_r3_tick", 32'(tick_o[3]), 32'(pat_t3[k]));
      checkOutput("ch3_r3_clk", 32'(clk_o[3]), 32'(pat_c3[k]));
    end

    // Global freeze with an ignored write and channel-enable change
    applyStimulus(1'b0, 4'b1111, 1'b1, 0, 9);
    for (int k = 0; k < 4; k++) wait_edge();
    applyStimulus(1'b1, 4'b1011, 1'b0, 0, 0);
    wait_edge();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] en;
      en = ch_en;
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      applyStimulus($urandom_range(0, 7) != 0, en, $urandom_range(0, 5) == 0,
                    $urandom_range(0, NCH - 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, 5));
`ifdef CLKDIV_ALIGN_EN
      align = ($urandom_range(0, 39) == 0);
`endif
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        wait_edge();
        rst_n = 1'b1;
      end else begin
        wait_edge();
      end
    end
`ifdef CLKDIV_ALIGN_EN
    align = 1'b0;
`endif

    // Asynchronous reset mid-period with a load pending
    applyStimulus(1'b1, 4'b1111, 1'b1, 1, 6);
    wait_edge();
    applyStimulus(1'b1, 4'b1111, 1'b0, 0, 0);
    wait_edge();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tick", 32'(tick_o), 32'd0);
    checkOutput("async_rst_clk", 32'(clk_o), 32'd0);
    checkOutput("async_rst_pend", 32'(div_pend), 32'd0);
    wait_edge();
    wait_edge();
    rst_n = 1'b1;
    wait_edge();
    checkOutput("post_rst_e1_tick", 32'(tick_o), 32'h0);
    checkOutput("post_rst_e1_clk", 32'(clk_o), 32'h0);
    wait_edge();
    checkOutput("post_rst_e2_tick", 32'(tick_o), 32'hf);
    checkOutput("post_rst_e2_clk", 32'(clk_o), 32'hf);

`ifdef CLKDIV_ALIGN_EN
    // ch0 and ch1 at R=4 started one cycle apart, then aligned
    applyStimulus(1'b1, 4'b0000, 1'b1, 0, 3);
    wait_edge();
    applyStimulus(1'b1, 4'b0000, 1'b1, 1, 3);
    wait_edge();
    applyStimulus(1'b1, 4'b0000, 1'b0, 0, 0);
    wait_edge();
    applyStimulus(1'b1, 4'b0001, 1'b0, 0, 0);
    wait_edge();
    applyStimulus(1'b1, 4'b0011, 1'b0, 0, 0);
    wait_edge();
    wait_edge();
    align = 1'b1;
    wait_edge();
    align = 1'b0;
    checkOutput("align_tick", 32'(tick_o[1:0]), 32'd0);
    checkOutput("align_clk", 32'(clk_o[1:0]), 32'd3);
    for (int k = 0; k < 4; k++) wait_edge();
    checkOutput("align_locked_tick", 32'(tick_o[1:0]), 32'd3);
`endif

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable multi-channel synchronous clock divider. It is the fully synchronous, parametrised successor to the fixed ripple /2–/16 divider. Each of NCH channels has a runtime-loadable ratio and produces two outputs from the single system clock: a one-cycle strobe (`tick_o`) and a near-50%-duty divided level (`clk_o`). It sits beside the top-level wrapper and feeds clock-enables to downstream logic; no derived clock ever drives a flop clock pin.

## Interface
- `NCH`, 4: number of divider channels (1–8).
- `CW`, 8: divisor register width. Ratio R = div+1, range 1..2^CW.
- `DIV_RST`, 1: divisor value loaded at reset (R=2).
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous active-low reset, released synchronously externally.
- `ena` input 1: global enable; low freezes all channel state (counters, outputs, pending loads).
- `ch_en` input NCH: per-channel run enable.
- `div_wr` input 1: one-cycle write strobe for a new divisor.
- `div_sel` input max(1,$clog2(NCH)): channel addressed by `div_wr`; out-of-range writes are ignored.
- `div_val` input CW: new divisor value (R = div_val+1).
- `div_pend` output NCH: per-channel flag; high while a written divisor is waiting to be applied.
- `tick_o` output NCH: registered one-cycle strobe, once per R enabled cycles.
- `clk_o` output NCH: registered divided level; high ceil(R/2) cycles, low floor(R/2) cycles.

## Operation
- Reset: `div`=DIV_RST; `cnt`=0; `shadow`=0; `div_pend`=0; `tick_o`=0; `clk_o`=0.
- Channel disabled (`ch_en[i]`=0, `ena`=1):
  - `cnt`←0, `tick_o`←0, `clk_o`←0.
  - If pending, `div`←`shadow` and `pend`←0.
- Channel running (`ena`=1, `ch_en[i]`=1), per edge:
  - If `cnt`==`div`: `cnt`←0 and `tick_o`←1.
  - Otherwise: `cnt`←`cnt`+1 and `tick_o`←0.
  - `clk_o`←(cnt_next < (div+2)>>1), computed in CW+1 bits.
- R=1 (div=0): `tick_o` and `clk_o` are held 1 every running cycle.
- Divisor load: `div_wr`=1 (and `ena`=1) → `shadow[sel]`←`div_val`, `pend[sel]`←1.
  - Applied on that channel's next terminal edge (`cnt`==`div`): `div`←`shadow`, `pend`←0.
  - The old period always completes, so there are no runt pulses.
- A write while already pending overwrites `shadow` (last write wins).
- A write on the same edge as the terminal count is not applied that edge; it takes effect at the following terminal count.
- `ena`=0 ignores `div_wr`.
- Async reset mid-period clears everything immediately; pending loads are lost.

## Timing
- Latency from enable: first `tick_o` is high after the R-th rising edge with `ch_en` and `ena` high.
- `clk_o` rises on the 1st edge of each period.
- Period after a load: new R starts at the edge after the terminal edge that applied it.
- `div_pend` is visible the edge after `div_wr` and falls on the applying terminal edge.
- All outputs are direct flop outputs; no combinational input-to-output paths.

## Configuration
- `CLKDIV_ALIGN_EN` defined: adds input `align` (1 bit).
  - `align`=1 with `ena`=1 forces every running channel to the phase-0 state: `cnt`←0, `tick_o`←0, `clk_o`←1.
  - Pending divisors are applied on that edge.
  - Disabled channels are unaffected.
  - All channels with equal R then stay phase-locked.
- Macro undefined: the `align` port and logic are absent; channels phase only from their own enable.

## Structure
- Package `clk_div_pkg`: default CW, DIV_RST, `NCH_MAX`=8, and the helper function for half-period threshold ((div+2)>>1).
- Sub-module `clk_div_chan`: one channel (`cnt`, `div`, `shadow`, `pend`, `tick`, `clk_o`), instantiated NCH times via generate.
- The top level decodes `div_sel` into per-channel write strobes and fans out `ena`/`align`.

## Test plan
- Reset then enable ch0 at default → `tick_o[0]` every 2 cycles, first after edge 2; `clk_o[0]` alternates 1,0.
- Write div_val=4 (R=5) to ch1 mid-period:
  - `div_pend[1]`=1 until the old terminal edge.
  - Then `tick_o` every 5 cycles and `clk_o` 3 high / 2 low.
- div_val=0 on ch2 → `tick_o[2]`=`clk_o[2]`=1 continuously while enabled; `ch_en`=0 → both 0 next edge.
- Two writes to ch3 (7 then 2) before terminal count → only R=3 is applied; `ena`=0 for 4 cycles freezes `cnt` and outputs exactly.
- Assert `rst_n`=0 mid-period with pending load → all outputs 0 asynchronously; after release, R=2 on all channels.
- `CLKDIV_ALIGN_EN`: ch0 R=4, ch1 R=4 started 1 cycle apart; pulse `align` → identical `tick_o` and `clk_o` thereafter.
